// File: rtl/bram_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_arbiter_if
// One requester port of the dual-port BRAM arbiter.
//
// A requester presents a word command (valid/address/write_enable/data_in)
// and sees it accepted when ready is high in the same cycle.
// Every accepted command gets exactly one response two cycles later:
// resp_valid pulses for one cycle, and data_out carries the RAM word.
// Writes are acknowledged too.
//
// Signals:
//   valid        requester -> arbiter  request present
//   ready        arbiter -> requester  request accepted this cycle
//   address      requester -> arbiter  word address
//   write_enable requester -> arbiter  per-lane write strobe, all zero = read
//   data_in      requester -> arbiter  write data
//   resp_valid   arbiter -> requester  one-cycle response strobe
//   data_out     arbiter -> requester  response word, held between responses
//
// Modports:
//   master  requester side
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface bram_arbiter_if #(
   parameter int ADDRESS_BITWIDTH = 16,
   parameter int DATA_BITWIDTH    = 32,
   parameter int LANES            = 4
);
   logic                        valid;
   logic                        ready;
   logic [ADDRESS_BITWIDTH-1:0] address;
   logic [LANES-1:0]            write_enable;
   logic [DATA_BITWIDTH-1:0]    data_in;
   logic                        resp_valid;
   logic [DATA_BITWIDTH-1:0]    data_out;

   modport master (
      output valid,
      output address,
      output write_enable,
      output data_in,
      input  ready,
      input  resp_valid,
      input  data_out
   );

   modport slave (
      input  valid,
      input  address,
      input  write_enable,
      input  data_in,
      output ready,
      output resp_valid,
      output data_out
   );
endinterface

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
// This module shares one single-port block RAM between two requesters, A and
// B. The block RAM has a registered read port, so read data appears one
// cycle after the address.
//
// Arbitration:
//   The arbiter makes its grant decision combinationally in the cycle of the
//   request. When only one port is valid, that port wins.
//   When both ports are valid, the winner depends on FIXED_PRIORITY:
//   - FIXED_PRIORITY = 1: A always wins.
//   - FIXED_PRIORITY = 0: the winner is the port named by a one-bit
//     round-robin pointer. The pointer flips after every grant.
//
// Pipeline:
//   The accepted command is registered onto the ram_* outputs.
//   A two-stage tag (valid, port id) travels alongside the command, so the
//   RAM word comes back to the right port exactly two cycles after
//   acceptance.
//
// Reset:
//   Reset is synchronous and active high. It drops any in-flight tags, so
//   nothing is answered after reset.
//   The RAM contents are not touched by reset.
//
// Ports:
//   clk               sole clock, rising edge
//   rst               synchronous active-high reset
//   a, b              requester ports (bram_arbiter_if.slave)
//   ram_write_enable  registered per-lane write strobe to RAM
//   ram_address       registered word address to RAM
//   ram_data_in       registered write data to RAM
//   ram_data_out      RAM registered read data (1-cycle latency)
// ---------------------------------------------------------------------------
module bram_arbiter #(
   parameter int ADDRESS_BITWIDTH     = 16,
   parameter int DATA_BITWIDTH        = 32,
   parameter int DATA_COLUMN_BITWIDTH = 8,
   parameter int FIXED_PRIORITY       = 0
) (
   input  logic                                          clk,
   input  logic                                          rst,
   bram_arbiter_if.slave                                 a,
   bram_arbiter_if.slave                                 b,
   output logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0] ram_write_enable,
   output logic [ADDRESS_BITWIDTH-1:0]                   ram_address,
   output logic [DATA_BITWIDTH-1:0]                      ram_data_in,
   input  logic [DATA_BITWIDTH-1:0]                      ram_data_out
);

   localparam int   LANES  = DATA_BITWIDTH / DATA_COLUMN_BITWIDTH;
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   // Grant and command selection.
   logic                        grant_a_s;
   logic                        grant_b_s;
   logic                        hs_s;
   logic                        hs_port_s;
   logic [LANES-1:0]            cmd_we_s;
   logic [ADDRESS_BITWIDTH-1:0] cmd_addr_s;
   logic [DATA_BITWIDTH-1:0]    cmd_data_s;

   // Round-robin pointer: names the port that wins a tie.
   logic                        ptr_r;

   // Response tag pipeline: stage 1 lines up with ram_*, stage 2 with ram_data_out.
   logic                        tag1_vld_r;
   logic                        tag1_port_r;
   logic                        tag2_vld_r;
   logic                        tag2_port_r;

   // Response strobes and held response words.
   logic                        a_resp_s;
   logic                        b_resp_s;
   logic [DATA_BITWIDTH-1:0]    a_hold_r;
   logic [DATA_BITWIDTH-1:0]    b_hold_r;

   // Combinational grant: at most one port is granted, and only when that port is valid.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (rst) begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end else if (a.valid && b.valid) begin
         if (FIXED_PRIORITY != 0) begin
            grant_a_s = 1'b1;
         end else if (ptr_r == PORT_A) begin
            grant_a_s = 1'b1;
         end else begin
            grant_b_s = 1'b1;
         end
      end else if (a.valid) begin
         grant_a_s = 1'b1;
      end else if (b.valid) begin
         grant_b_s = 1'b1;
      end else begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end
   end

   // Select the winning port's command. The command bits of a losing or idle
   // port never reach the RAM.
   always_comb begin
      hs_s       = grant_a_s | grant_b_s;
      hs_port_s  = PORT_A;
      cmd_we_s   = {LANES{1'b0}};
      cmd_addr_s = {ADDRESS_BITWIDTH{1'b0}};
      cmd_data_s = {DATA_BITWIDTH{1'b0}};
      if (grant_b_s) begin
         hs_port_s  = PORT_B;
         cmd_we_s   = b.write_enable;
         cmd_addr_s = b.address;
         cmd_data_s = b.data_in;
      end else if (grant_a_s) begin
         hs_port_s  = PORT_A;
         cmd_we_s   = a.write_enable;
         cmd_addr_s = a.address;
         cmd_data_s = a.data_in;
      end else begin
         hs_port_s  = PORT_A;
         cmd_we_s   = {LANES{1'b0}};
         cmd_addr_s = {ADDRESS_BITWIDTH{1'b0}};
         cmd_data_s = {DATA_BITWIDTH{1'b0}};
      end
   end

   // RAM command register. The write strobe drops to zero after any cycle
   // without a handshake. Address and data keep their last value, which
   // limits toggling on the RAM pins.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_write_enable <= {LANES{1'b0}};
         ram_address      <= {ADDRESS_BITWIDTH{1'b0}};
         ram_data_in      <= {DATA_BITWIDTH{1'b0}};
      end else if (hs_s) begin
         ram_write_enable <= cmd_we_s;
         ram_address      <= cmd_addr_s;
         ram_data_in      <= cmd_data_s;
      end else begin
         ram_write_enable <= {LANES{1'b0}};
         ram_address      <= ram_address;
         ram_data_in      <= ram_data_in;
      end
   end

   // Round-robin pointer: flips after every grant, and holds on idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= PORT_A;
      end else if (hs_s) begin
         ptr_r <= ~ptr_r;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Two-stage response tag pipeline, matched to the registered RAM read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag1_vld_r  <= 1'b0;
         tag1_port_r <= PORT_A;
         tag2_vld_r  <= 1'b0;
         tag2_port_r <= PORT_A;
      end else begin
         tag1_vld_r  <= hs_s;
         tag1_port_r <= hs_port_s;
         tag2_vld_r  <= tag1_vld_r;
         tag2_port_r <= tag1_port_r;
      end
   end

   // Only one tag reaches stage 2 per cycle, so the two strobes are exclusive.
   assign a_resp_s = (!rst) && tag2_vld_r && (tag2_port_r == PORT_A);
   assign b_resp_s = (!rst) && tag2_vld_r && (tag2_port_r == PORT_B);

   // Capture each port's response word, so its data_out holds between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_hold_r <= {DATA_BITWIDTH{1'b0}};
         b_hold_r <= {DATA_BITWIDTH{1'b0}};
      end else begin
         if (a_resp_s) begin
            a_hold_r <= ram_data_out;
         end else begin
            a_hold_r <= a_hold_r;
         end
         if (b_resp_s) begin
            b_hold_r <= ram_data_out;
         end else begin
            b_hold_r <= b_hold_r;
         end
      end
   end

   assign a.ready      = grant_a_s;
   assign b.ready      = grant_b_s;
   assign a.resp_valid = a_resp_s;
   assign b.resp_valid = b_resp_s;
   assign a.data_out   = a_resp_s ? ram_data_out : a_hold_r;
   assign b.data_out   = b_resp_s ? ram_data_out : b_hold_r;

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
// This bench drives two arbiter instances with directed vectors:
//   - u_rr uses round-robin arbitration (FIXED_PRIORITY = 0).
//   - u_fp uses fixed priority (FIXED_PRIORITY = 1).
// Each instance is backed by a behavioural byte-lane RAM with a registered
// read port that returns the old word on a write.
// Inputs change just after the falling edge, and outputs are checked 1 ns
// later.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   bram_arbiter_if #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32), .LANES(4)) ra ();
   bram_arbiter_if #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32), .LANES(4)) rb ();
   bram_arbiter_if #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32), .LANES(4)) fa ();
   bram_arbiter_if #(.ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32), .LANES(4)) fb ();

   logic [3:0]  rr_ram_we;
   logic [15:0] rr_ram_addr;
   logic [31:0] rr_ram_din;
   logic [31:0] rr_ram_dout;
   logic [3:0]  fp_ram_we;
   logic [15:0] fp_ram_addr;
   logic [31:0] fp_ram_din;
   logic [31:0] fp_ram_dout;

   logic [31:0] mem_rr [0:255];
   logic [31:0] mem_fp [0:255];

   bram_arbiter #(
      .ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32), .DATA_COLUMN_BITWIDTH(8), .FIXED_PRIORITY(0)
   ) u_rr (
      .clk(clk), .rst(rst), .a(ra), .b(rb),
      .ram_write_enable(rr_ram_we), .ram_address(rr_ram_addr),
      .ram_data_in(rr_ram_din), .ram_data_out(rr_ram_dout)
   );

   bram_arbiter #(
      .ADDRESS_BITWIDTH(16), .DATA_BITWIDTH(32), .DATA_COLUMN_BITWIDTH(8), .FIXED_PRIORITY(1)
   ) u_fp (
      .clk(clk), .rst(rst), .a(fa), .b(fb),
      .ram_write_enable(fp_ram_we), .ram_address(fp_ram_addr),
      .ram_data_in(fp_ram_din), .ram_data_out(fp_ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM for u_rr: registered read, old data on write, byte-lane strobes.
   always @(posedge clk) begin
      rr_ram_dout <= mem_rr[rr_ram_addr[7:0]];
      for (int i = 0; i < 4; i++) begin
         if (rr_ram_we[i]) begin
            mem_rr[rr_ram_addr[7:0]][i*8 +: 8] <= rr_ram_din[i*8 +: 8];
         end
      end
   end

   // Behavioural RAM for u_fp.
   always @(posedge clk) begin
      fp_ram_dout <= mem_fp[fp_ram_addr[7:0]];
      for (int j = 0; j < 4; j++) begin
         if (fp_ram_we[j]) begin
            mem_fp[fp_ram_addr[7:0]][j*8 +: 8] <= fp_ram_din[j*8 +: 8];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic drv_a(input logic v, input logic [15:0] ad, input logic [3:0] we, input logic [31:0] d);
      ra.valid = v; ra.address = ad; ra.write_enable = we; ra.data_in = d;
   endtask

   task automatic drv_b(input logic v, input logic [15:0] ad, input logic [3:0] we, input logic [31:0] d);
      rb.valid = v; rb.address = ad; rb.write_enable = we; rb.data_in = d;
   endtask

   task automatic drv_fa(input logic v, input logic [15:0] ad);
      fa.valid = v; fa.address = ad; fa.write_enable = 4'h0; fa.data_in = 32'h0;
   endtask

   task automatic drv_fb(input logic v, input logic [15:0] ad);
      fb.valid = v; fb.address = ad; fb.write_enable = 4'h0; fb.data_in = 32'h0;
   endtask

   // Idle ports carry garbage command bits that must never reach the RAM.
   task automatic idle_rr();
      drv_a(1'b0, 16'hFFFF, 4'hF, 32'hFFFF_FFFF);
      drv_b(1'b0, 16'hFFFF, 4'hF, 32'hFFFF_FFFF);
   endtask

   initial begin
      logic exp_ar, exp_br, exp_ars, exp_brs;

      rst = 1'b1;
      idle_rr();
      drv_fa(1'b0, 16'h0);
      drv_fb(1'b0, 16'h0);

      // Reset state.
      @(negedge clk); #1;
      chk("rst_ram_we",   {28'h0, rr_ram_we}, 32'h0);
      chk("rst_ram_addr", {16'h0, rr_ram_addr}, 32'h0);
      chk("rst_ram_din",  rr_ram_din, 32'h0);
      chk("rst_a_dout",   ra.data_out, 32'h0);
      chk("rst_b_dout",   rb.data_out, 32'h0);
      chk("rst_a_ready",  {31'h0, ra.ready}, 32'h0);
      chk("rst_a_resp",   {31'h0, ra.resp_valid}, 32'h0);

      // Preload via B: 0x10, 0x20, 0x30 back to back.
      @(negedge clk); rst = 1'b0; drv_b(1'b1, 16'h0010, 4'hF, 32'h0A0B_0C0D); #1;
      chk("w1_b_ready", {31'h0, rb.ready}, 32'h1);
      chk("w1_a_ready", {31'h0, ra.ready}, 32'h0);
      @(negedge clk); drv_b(1'b1, 16'h0020, 4'hF, 32'h1122_3344); #1;
      chk("w2_b_ready",  {31'h0, rb.ready}, 32'h1);
      chk("w2_ram_we",   {28'h0, rr_ram_we}, 32'hF);
      chk("w2_ram_addr", {16'h0, rr_ram_addr}, 32'h10);
      chk("w2_ram_din",  rr_ram_din, 32'h0A0B_0C0D);
      @(negedge clk); drv_b(1'b1, 16'h0030, 4'hF, 32'h5566_7788); #1;
      chk("w3_b_resp", {31'h0, rb.resp_valid}, 32'h1);
      chk("w3_a_resp", {31'h0, ra.resp_valid}, 32'h0);
      @(negedge clk); idle_rr(); #1;
      chk("w4_ram_addr", {16'h0, rr_ram_addr}, 32'h30);
      @(negedge clk); #1;
      chk("idle_ram_we",   {28'h0, rr_ram_we}, 32'h0);
      chk("idle_ram_addr", {16'h0, rr_ram_addr}, 32'h30);
      chk("idle_ram_din",  rr_ram_din, 32'h5566_7788);
      @(negedge clk); #1;

      // A write request held during reset must not be accepted.
      @(negedge clk); rst = 1'b1; drv_a(1'b1, 16'h0030, 4'hF, 32'hDEAD_BEEF); #1;
      chk("rstw_a_ready", {31'h0, ra.ready}, 32'h0);
      @(negedge clk); rst = 1'b0; idle_rr(); #1;
      chk("rstw_ram_we", {28'h0, rr_ram_we}, 32'h0);

      // A reads 0x10 while B is idle.
      @(negedge clk); drv_a(1'b1, 16'h0010, 4'h0, 32'h0); #1;
      chk("rd_a_ready", {31'h0, ra.ready}, 32'h1);
      chk("rd_b_ready", {31'h0, rb.ready}, 32'h0);
      @(negedge clk); idle_rr(); #1;
      chk("rd_ram_addr", {16'h0, rr_ram_addr}, 32'h10);
      chk("rd_ram_we",   {28'h0, rr_ram_we}, 32'h0);
      chk("rd_a_resp_n1", {31'h0, ra.resp_valid}, 32'h0);
      @(negedge clk); #1;
      chk("rd_a_resp", {31'h0, ra.resp_valid}, 32'h1);
      chk("rd_a_data", ra.data_out, 32'h0A0B_0C0D);
      chk("rd_b_resp", {31'h0, rb.resp_valid}, 32'h0);
      @(negedge clk); #1;
      chk("rd_a_resp_off", {31'h0, ra.resp_valid}, 32'h0);
      chk("rd_a_hold",     ra.data_out, 32'h0A0B_0C0D);

      // Partial write to 0x20, then a read of 0x20, then a read of 0x30.
      @(negedge clk); drv_a(1'b1, 16'h0020, 4'b0011, 32'hAABB_CCDD); #1;
      chk("pw_a_ready", {31'h0, ra.ready}, 32'h1);
      @(negedge clk); drv_a(1'b1, 16'h0020, 4'h0, 32'h0); #1;
      chk("pr_a_ready", {31'h0, ra.ready}, 32'h1);
      chk("pw_ram_we",  {28'h0, rr_ram_we}, 32'h3);
      @(negedge clk); drv_a(1'b1, 16'h0030, 4'h0, 32'h0); #1;
      chk("pw_ack_resp", {31'h0, ra.resp_valid}, 32'h1);
      chk("pw_ack_data", ra.data_out, 32'h1122_3344);
      @(negedge clk); idle_rr(); #1;
      chk("pr_resp", {31'h0, ra.resp_valid}, 32'h1);
      chk("pr_data", ra.data_out, 32'h1122_CCDD);
      @(negedge clk); #1;
      chk("rstw_word_kept", ra.data_out, 32'h5566_7788);

      // Round robin after reset: both ports valid for 6 cycles.
      @(negedge clk); rst = 1'b1; #1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         rst = 1'b0;
         if (k < 6) begin
            drv_a(1'b1, 16'h0010, 4'h0, 32'h0);
            drv_b(1'b1, 16'h0030, 4'h0, 32'h0);
         end else begin
            idle_rr();
         end
         #1;
         exp_ar  = (k < 6) && (k % 2 == 0);
         exp_br  = (k < 6) && (k % 2 == 1);
         exp_ars = (k >= 2) && (k % 2 == 0);
         exp_brs = (k >= 3) && (k % 2 == 1);
         chk($sformatf("rr_a_ready[%0d]", k), {31'h0, ra.ready}, {31'h0, exp_ar});
         chk($sformatf("rr_b_ready[%0d]", k), {31'h0, rb.ready}, {31'h0, exp_br});
         chk($sformatf("rr_a_resp[%0d]", k),  {31'h0, ra.resp_valid}, {31'h0, exp_ars});
         chk($sformatf("rr_b_resp[%0d]", k),  {31'h0, rb.resp_valid}, {31'h0, exp_brs});
         chk($sformatf("rr_both_resp[%0d]", k), {31'h0, ra.resp_valid & rb.resp_valid}, 32'h0);
         if (exp_ars) chk($sformatf("rr_a_data[%0d]", k), ra.data_out, 32'h0A0B_0C0D);
         if (exp_brs) chk($sformatf("rr_b_data[%0d]", k), rb.data_out, 32'h5566_7788);
      end

      // A B write is accepted, then reset is pulsed: the in-flight write gets
      // no response, and the pointer returns to A.
      @(negedge clk); drv_b(1'b1, 16'h0040, 4'hF, 32'h9988_7766); #1;
      chk("rb_b_ready", {31'h0, rb.ready}, 32'h1);
      @(negedge clk); rst = 1'b1; drv_b(1'b1, 16'h0030, 4'h0, 32'h0); #1;
      chk("rb_b_ready_rst", {31'h0, rb.ready}, 32'h0);
      chk("rb_b_resp_rst",  {31'h0, rb.resp_valid}, 32'h0);
      @(negedge clk); rst = 1'b0; idle_rr(); #1;
      chk("rb_b_resp_n2", {31'h0, rb.resp_valid}, 32'h0);
      @(negedge clk);
      drv_a(1'b1, 16'h0010, 4'h0, 32'h0);
      drv_b(1'b1, 16'h0030, 4'h0, 32'h0);
      #1;
      chk("rb_grant_a", {31'h0, ra.ready}, 32'h1);
      chk("rb_grant_b", {31'h0, rb.ready}, 32'h0);
      chk("rb_b_resp_n3", {31'h0, rb.resp_valid}, 32'h0);
      @(negedge clk); idle_rr(); #1;
      chk("rb_b_resp_n4", {31'h0, rb.resp_valid}, 32'h0);
      @(negedge clk); #1;
      chk("rb_a_resp", {31'h0, ra.resp_valid}, 32'h1);
      chk("rb_a_data", ra.data_out, 32'h0A0B_0C0D);
      chk("rb_b_resp_n5", {31'h0, rb.resp_valid}, 32'h0);

      // Fixed priority: A wins 4 cycles, then B is granted once A drops valid.
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         drv_fa(k < 4, 16'h0010);
         drv_fb(k < 5, 16'h0020);
         #1;
         chk($sformatf("fp_a_ready[%0d]", k), {31'h0, fa.ready}, {31'h0, k < 4});
         chk($sformatf("fp_b_ready[%0d]", k), {31'h0, fb.ready}, {31'h0, k == 4});
         chk($sformatf("fp_a_resp[%0d]", k),  {31'h0, fa.resp_valid}, {31'h0, (k >= 2) && (k < 6)});
         chk($sformatf("fp_b_resp[%0d]", k),  {31'h0, fb.resp_valid}, {31'h0, k == 6});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 16, word address width.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 32, word width.
REQ-003 SHALL have parameter DATA_COLUMN_BITWIDTH, default 8, byte-lane width; lanes = DATA_BITWIDTH/DATA_COLUMN_BITWIDTH = 4.
REQ-004 SHALL have parameter FIXED_PRIORITY, default 0; 0 = round-robin, 1 = port A always wins.
REQ-005 SHALL have: clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have per port p in {a,b}: p_valid  in  1  request present.
REQ-008 SHALL have: p_ready  out  1  request accepted this cycle.
REQ-009 SHALL have: p_address  in  ADDRESS_BITWIDTH  word address.
REQ-010 SHALL have: p_write_enable  in  4  per-lane write strobe; 0000 = read.
REQ-011 SHALL have: p_data_in  in  DATA_BITWIDTH  write data.
REQ-012 SHALL have: p_resp_valid  out  1  response strobe, one cycle.
REQ-013 SHALL have: p_data_out  out  DATA_BITWIDTH  response word.
REQ-014 SHALL have RAM side: ram_write_enable out 4, ram_address out ADDRESS_BITWIDTH, ram_data_in out DATA_BITWIDTH (all registered), ram_data_out in DATA_BITWIDTH (RAM registered read port, 1-cycle latency, read-old-on-write).

Function
REQ-015 SHALL grant combinationally in cycle N: p_ready = 1 for at most one port, only if p_valid = 1; handshake = p_valid & p_ready.
REQ-016 SHALL, with one port valid, grant it regardless of priority.
REQ-017 SHALL, with both valid and FIXED_PRIORITY = 0, grant the port named by the priority pointer; pointer toggles to the other port after every grant, unchanged on idle cycles.
REQ-018 SHALL, with FIXED_PRIORITY = 1, always grant A when a_valid = 1.
REQ-019 SHALL accept up to one request per cycle, no bubbles between back-to-back requests.
REQ-020 SHALL register the accepted command into ram_* at end of cycle N; ram_* hold it during N+1.
REQ-021 SHALL drive ram_write_enable = 0000 in any cycle following a cycle with no handshake; ram_address and ram_data_in hold last value.
REQ-022 SHALL carry a 2-stage pipeline tag (valid, port id) alongside the command.
REQ-023 SHALL assert p_resp_valid in cycle N+2 for the port accepted in N, with p_data_out = ram_data_out; fixed latency 2, in acceptance order.
REQ-024 SHALL respond to writes too (write ack); data_out = word content before the write.
REQ-025 SHALL never assert a_resp_valid and b_resp_valid in the same cycle.
REQ-026 SHALL hold p_data_out from its last response while p_resp_valid = 0.
REQ-027 SHALL have no response backpressure; requesters always take responses.
REQ-028 SHALL keep p_address, p_write_enable, p_data_in don't-care while p_valid = 0; those bits SHALL never reach ram_write_enable.
REQ-029 SHALL make a read accepted in the cycle after a write to the same address return the written data (RAM ordering, no forwarding logic).

Reset
REQ-030 SHALL, on a rising edge with rst = 1: ram_write_enable = 0000, ram_address = 0, ram_data_in = 0, pipeline tags invalid, priority pointer = A, p_data_out = 0.
REQ-031 SHALL drive p_ready = 0 and p_resp_valid = 0 while rst = 1.
REQ-032 SHALL drop in-flight requests on reset mid-operation, with no response after reset deasserts; RAM contents not reset.

Verification
REQ-033 A read 0x0010, B idle -> a_ready in N, ram_address = 0x0010 in N+1, a_resp_valid with stored word in N+2.
REQ-034 A write 0x0020 we=0011 data 0xAABBCCDD over word 0x11223344, then A read 0x0020 -> write ack returns 0x11223344; read returns 0x1122CCDD.
REQ-035 Both valid continuously 6 cycles, round-robin, after reset -> grants A,B,A,B,A,B; responses alternate, 2-cycle latency, never both same cycle.
REQ-036 FIXED_PRIORITY = 1, both valid 4 cycles -> A granted 4 times, b_ready stays 0; B granted first cycle A drops valid.
REQ-037 rst pulsed one cycle after a B write (we=1111) accepted -> no b_resp_valid afterwards; next grant with both valid goes to A.
REQ-038 A valid with we=1111 while rst = 1 -> a_ready = 0, ram_write_enable = 0000, RAM word unchanged.
